// File: rtl/run_ctrl_stats_pkg.sv
// Shared types and constants for the run-control / statistics unit.
package run_ctrl_stats_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StPaused = 2'd1,
        StExited = 2'd2
    } state_e;

    localparam logic [2:0] CH_PRINT = 3'd0;
    localparam logic [2:0] CH_INSTR = 3'd1;
    localparam logic [2:0] CH_BR    = 3'd2;
    localparam logic [2:0] CH_TAKEN = 3'd3;
    localparam logic [2:0] CH_JUMP  = 3'd4;
    localparam logic [2:0] CH_PC    = 3'd5;
    localparam logic [2:0] CH_STATE = 3'd6;
    localparam logic [2:0] CH_ZERO  = 3'd7;

    localparam int unsigned DEF_EXIT_CODE  = 10;
    localparam int unsigned DEF_PRINT_CODE = 34;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl_stats.sv
// Run control (exit / print-pause / breakpoint / single-step) gating PC advance,
// plus retire statistics and a registered display channel mux.
module run_ctrl_stats
    import run_ctrl_stats_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned PC_W           = 32,
    parameter int unsigned EXIT_CODE      = DEF_EXIT_CODE,
    parameter int unsigned PRINT_CODE     = DEF_PRINT_CODE,
    parameter bit          PAUSE_ON_PRINT = 1'b1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              go,
    input  logic              step_mode,
    input  logic              syscall,
    input  logic [DATA_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    input  logic [PC_W-1:0]   pc,
    input  logic              is_branch,
    input  logic              branch_taken,
    input  logic              is_jump,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [2:0]        disp_sel,
    output logic              pc_enable,
    output logic              halted,
    output logic              paused,
    output logic [DATA_W-1:0] disp_data
);

    state_e            state_q, state_d;
    logic              go_q;
    logic              bp_skip_q, bp_skip_d;
    logic [DATA_W-1:0] print_q, print_d;
    logic [DATA_W-1:0] disp_d;
    logic [DATA_W-1:0] instr_cnt, br_cnt, taken_cnt, jump_cnt;
    logic              go_rise, is_exit, is_print, bp_hit;

    assign go_rise  = go & ~go_q;
    assign is_exit  = syscall && (v0 == DATA_W'(EXIT_CODE));
    assign is_print = syscall && (v0 == DATA_W'(PRINT_CODE));
    // bp_skip lets the instruction we paused on retire once after resuming.
    assign bp_hit   = bp_en && (pc == bp_addr) && !bp_skip_q;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            go_q      <= 1'b0;
            bp_skip_q <= 1'b0;
            print_q   <= '0;
            disp_data <= '0;
        end else begin
            state_q   <= state_d;
            go_q      <= go;
            bp_skip_q <= bp_skip_d;
            print_q   <= print_d;
            disp_data <= disp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bp_skip_d = bp_skip_q;
        print_d   = print_q;
        pc_enable = 1'b0;
        unique case (state_q)
            StRun: begin
                if (is_exit) begin
                    state_d = StExited;
                end else if (bp_hit) begin
                    state_d = StPaused;
                end else begin
                    pc_enable = 1'b1;
                    bp_skip_d = 1'b0;
                    if (is_print) begin
                        print_d = a0;
                        if (PAUSE_ON_PRINT) state_d = StPaused;
                    end
                    if (step_mode) state_d = StPaused;
                end
            end
            StPaused: begin
                if (go_rise) begin
                    state_d   = StRun;
                    bp_skip_d = 1'b1;
                end
            end
            StExited: ;
            default: state_d = StRun;
        endcase
    end

    assign halted = (state_q == StExited);
    assign paused = (state_q == StPaused);

    sat_counter #(.W(DATA_W)) u_instr_cnt (
        .CLK (CLK),
        .rst (rst),
        .inc (pc_enable),
        .q   (instr_cnt)
    );

    sat_counter #(.W(DATA_W)) u_jump_cnt (
        .CLK (CLK),
        .rst (rst),
        .inc (pc_enable & is_jump),
        .q   (jump_cnt)
    );

    sat_counter #(.W(DATA_W)) u_br_cnt (
        .CLK (CLK),
        .rst (rst),
        .inc (pc_enable & is_branch),
        .q   (br_cnt)
    );

    sat_counter #(.W(DATA_W)) u_taken_cnt (
        .CLK (CLK),
        .rst (rst),
        .inc (pc_enable & is_branch & branch_taken),
        .q   (taken_cnt)
    );

    always_comb begin
        disp_d = '0;
        unique case (disp_sel)
            CH_PRINT: disp_d = print_q;
            CH_INSTR: disp_d = instr_cnt;
            CH_BR:    disp_d = br_cnt;
            CH_TAKEN: disp_d = taken_cnt;
            CH_JUMP:  disp_d = jump_cnt;
            CH_PC:    disp_d = DATA_W'(pc);
            CH_STATE: disp_d = DATA_W'({halted, paused});
            CH_ZERO:  disp_d = '0;
            default:  disp_d = '0;
        endcase
    end

endmodule

// File: tb/tb_run_ctrl_stats.sv
// Directed bench for run_ctrl_stats: reference model checked every cycle plus literal checks.
module tb_run_ctrl_stats;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0, step_mode = 1'b0, syscall = 1'b0;
    logic [31:0] v0 = '0, a0 = '0, pc = '0, bp_addr = '0;
    logic        is_branch = 1'b0, branch_taken = 1'b0, is_jump = 1'b0, bp_en = 1'b0;
    logic [2:0]  disp_sel = 3'd0;
    logic        pc_enable, halted, paused;
    logic [31:0] disp_data;

    // Narrow instance, free-running retire, used for the saturation check.
    logic        z1 = 1'b0;
    logic [3:0]  z4 = 4'd0;
    logic [31:0] z32 = '0;
    logic [2:0]  sel4 = 3'd1;
    logic        pc_enable4, halted4, paused4;
    logic [3:0]  disp4;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    always #5 CLK = ~CLK;

    run_ctrl_stats dut (
        .CLK(CLK), .rst(rst), .go(go), .step_mode(step_mode), .syscall(syscall),
        .v0(v0), .a0(a0), .pc(pc), .is_branch(is_branch), .branch_taken(branch_taken),
        .is_jump(is_jump), .bp_en(bp_en), .bp_addr(bp_addr), .disp_sel(disp_sel),
        .pc_enable(pc_enable), .halted(halted), .paused(paused), .disp_data(disp_data)
    );

    run_ctrl_stats #(.DATA_W(4)) dut4 (
        .CLK(CLK), .rst(rst), .go(z1), .step_mode(z1), .syscall(z1),
        .v0(z4), .a0(z4), .pc(z32), .is_branch(z1), .branch_taken(z1),
        .is_jump(z1), .bp_en(z1), .bp_addr(z32), .disp_sel(sel4),
        .pc_enable(pc_enable4), .halted(halted4), .paused(paused4), .disp_data(disp4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = running, 1 = paused, 2 = exited.
    int          m_st;
    logic        m_goq, m_skip;
    logic [31:0] m_print, m_instr, m_br, m_taken, m_jump, m_disp;

    function automatic logic [31:0] sat(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    function automatic logic exp_pc_en();
        if (m_st != 0) return 1'b0;
        if (syscall && v0 == 32'd10) return 1'b0;
        if (bp_en && pc == bp_addr && !m_skip) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] chan(input logic [2:0] s);
        case (s)
            3'd0: return m_print;
            3'd1: return m_instr;
            3'd2: return m_br;
            3'd3: return m_taken;
            3'd4: return m_jump;
            3'd5: return pc;
            3'd6: return {30'd0, m_st == 2, m_st == 1};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge CLK or negedge rst) begin
        if (!rst) begin
            m_st <= 0; m_goq <= 1'b0; m_skip <= 1'b0; m_print <= '0;
            m_instr <= '0; m_br <= '0; m_taken <= '0; m_jump <= '0; m_disp <= '0;
        end else begin
            m_goq  <= go;
            m_disp <= chan(disp_sel);
            if (exp_pc_en()) begin
                m_skip  <= 1'b0;
                m_instr <= sat(m_instr);
                if (is_jump) m_jump <= sat(m_jump);
                if (is_branch) m_br <= sat(m_br);
                if (is_branch && branch_taken) m_taken <= sat(m_taken);
                if (syscall && v0 == 32'd34) m_print <= a0;
                if ((syscall && v0 == 32'd34) || step_mode) m_st <= 1;
            end else if (m_st == 0) begin
                m_st <= (syscall && v0 == 32'd10) ? 2 : 1;
            end else if (m_st == 1 && go && !m_goq) begin
                m_st   <= 0;
                m_skip <= 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (check_en && rst) begin
            check("pc_enable", {31'd0, pc_enable}, {31'd0, exp_pc_en()});
            check("halted", {31'd0, halted}, {31'd0, m_st == 2});
            check("paused", {31'd0, paused}, {31'd0, m_st == 1});
            check("disp_data", disp_data, m_disp);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        pc = 32'h100;
        disp_sel = 3'd1;
        #12;
        check("rst_disp", disp_data, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_paused", {31'd0, paused}, 32'd0);
        check("rst_pc_en", {31'd0, pc_enable}, 32'd1);
        @(posedge CLK); #1;
        rst = 1'b1;
        check_en = 1'b1;

        // Free run: five retires visible one cycle later.
        tick(6);
        check("run_instr", disp_data, 32'd5);

        // Print syscall retires, latches a0, pauses.
        syscall = 1'b1; v0 = 32'd34; a0 = 32'h1234; disp_sel = 3'd0;
        #0 check("print_pc_en", {31'd0, pc_enable}, 32'd1);
        tick(1);
        syscall = 1'b0; v0 = '0;
        check("print_paused", {31'd0, paused}, 32'd1);
        tick(1);
        check("print_disp", disp_data, 32'h1234);
        tick(3);
        check("print_hold", {31'd0, pc_enable}, 32'd0);
        go = 1'b1;
        tick(1);
        check("print_resume", {31'd0, paused}, 32'd0);
        go = 1'b0;

        // Breakpoint at 0x10: trap, resume, no re-trap on the same PC.
        bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h8; disp_sel = 3'd1;
        tick(1);
        pc = 32'h10;
        #0 check("bp_trap", {31'd0, pc_enable}, 32'd0);
        tick(4);
        check("bp_paused", {31'd0, paused}, 32'd1);
        check("bp_frozen", disp_data, 32'd8);
        go = 1'b1;
        tick(1);
        check("bp_no_retrap", {31'd0, pc_enable}, 32'd1);
        tick(1);
        pc = 32'h14; go = 1'b0;
        tick(1);
        check("bp_retired", disp_data, 32'd9);
        bp_en = 1'b0;

        // Single-step: one retire entering step mode, then one per go rise.
        step_mode = 1'b1; pc = 32'h20;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            go = 1'b1; tick(1);
            go = 1'b0; tick(2);
        end
        check("step_three", disp_data, 32'd14);
        go = 1'b1;
        tick(6);
        go = 1'b0;
        tick(2);
        check("step_held", disp_data, 32'd15);
        step_mode = 1'b0; go = 1'b1;
        tick(1);
        go = 1'b0;

        // Branch / jump statistics.
        for (int i = 0; i < 7; i++) begin
            is_branch    = (i == 0 || i == 1 || i == 3 || i == 5);
            branch_taken = (i == 0 || i == 3);
            is_jump      = (i == 2 || i == 4 || i == 6);
            tick(1);
        end
        is_branch = 1'b0; branch_taken = 1'b0; is_jump = 1'b0;
        disp_sel = 3'd2; tick(1); check("br_cnt", disp_data, 32'd4);
        disp_sel = 3'd3; tick(1); check("taken_cnt", disp_data, 32'd2);
        disp_sel = 3'd4; tick(1); check("jump_cnt", disp_data, 32'd3);
        pc = 32'hABC; disp_sel = 3'd5; tick(1); check("pc_chan", disp_data, 32'hABC);
        disp_sel = 3'd7; tick(1); check("zero_chan", disp_data, 32'd0);

        // Exit: no retire, go ignored.
        syscall = 1'b1; v0 = 32'd10; disp_sel = 3'd6;
        #0 check("exit_pc_en", {31'd0, pc_enable}, 32'd0);
        tick(1);
        syscall = 1'b0; v0 = '0;
        check("exit_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            go = ~go;
            tick(1);
        end
        go = 1'b0;
        check("exit_stays", {31'd0, halted}, 32'd1);
        check("state_chan", disp_data, 32'd2);

        // Asynchronous reset mid-cycle.
        disp_sel = 3'd2;
        #2 rst = 1'b0;
        #1;
        check("arst_halted", {31'd0, halted}, 32'd0);
        check("arst_disp", disp_data, 32'd0);
        @(negedge CLK); #1;
        rst = 1'b1;
        tick(2);
        check("arst_br_clear", disp_data, 32'd0);

        // Narrow instance retires every cycle and must stick at 15.
        tick(22);
        check("sat4", {28'd0, disp4}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
